shift_pipe_stage: RTL and testbench

Pipelined, handshaked shift execution stage for the ALU datapath. Accepts shift operations (operand, placing word, size, type, direction, tag) from the issue stage via valid/ready. Computes left or right LOGIC/ARITHMETIC/DOUBLE_PRECISION/CYCLIC shifts with carry and zero flags. Delivers results to writeback through a 2-entry pipeline with full backpressure.

---
 rtl/shift_pipe_stage.sv | 180 ++++++++++++++++++
 tb/tb_shift_pipe_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage
//   Two-register, valid/ready handshaked shift execution stage.
//   S1 captures the operation; the shift is computed from S1 and registered
//   into S2, which drives the result ports. Full backpressure: a stalled S2
//   holds, S1 fills behind it, then in_ready_o drops.
//
// Ports
//   clk_i, rst_n_i          clock (rising edge) / async active-low reset
//   flush_i                 synchronous drop of every in-flight operation
//   in_valid_i, in_ready_o  issue-side handshake
//   d_i, c_i                word to shift / placing bits for DOUBLE_PRECISION
//   shift_size_i            shift amount n
//   shift_type_i            0 LOGIC, 1 ARITHMETIC, 2 DOUBLE_PRECISION, 3 CYCLIC
//   shift_dir_i             0 left, 1 right
//   tag_i, tag_o            opaque tag carried with the operation
//   out_valid_o, out_ready_i writeback-side handshake
//   d_o, carry_o, zero_o    result, last bit shifted out, result == 0
module shift_pipe_stage #(
  parameter int WORD_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [WORD_WIDTH-1:0]         d_i,
  input  logic [WORD_WIDTH-2:0]         c_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
  input  logic [1:0]                    shift_type_i,
  input  logic                          shift_dir_i,
  input  logic [TAG_WIDTH-1:0]          tag_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [WORD_WIDTH-1:0]         d_o,
  output logic                          carry_o,
  output logic                          zero_o,
  output logic [TAG_WIDTH-1:0]          tag_o
);

  localparam int SW = $clog2(WORD_WIDTH);

  localparam logic [1:0] TYPE_LOGIC  = 2'd0;
  localparam logic [1:0] TYPE_ARITH  = 2'd1;
  localparam logic [1:0] TYPE_DOUBLE = 2'd2;
  localparam logic [1:0] TYPE_CYCLIC = 2'd3;

  // S1 operand register
  logic                  v1;
  logic [WORD_WIDTH-1:0] s1_d;
  logic [WORD_WIDTH-2:0] s1_c;
  logic [SW-1:0]         s1_n;
  logic [1:0]            s1_type;
  logic                  s1_dir;
  logic [TAG_WIDTH-1:0]  s1_tag;

  // Handshake / advance enables
  logic s1_en;
  logic s2_en;

  // Shift datapath
  logic [WORD_WIDTH-1:0] fill_l;
  logic [WORD_WIDTH-1:0] fill_r;
  logic [WORD_WIDTH-1:0] shift_res;
  logic                  shift_carry;
  logic [SW-1:0]         left_idx;
  logic [SW-1:0]         right_idx;

  // S2 may advance when empty or being drained; S1 when empty or moving into S2.
  // in_ready_o depends only on state and out_ready_i, never on in_valid_i.
  assign s2_en      = !out_valid_o || out_ready_i;
  assign s1_en      = !v1 || s2_en;
  assign in_ready_o = s1_en;

  // The shift is done on a double-width concatenation: the fill word supplies
  // the bits entering from the far side, so one shifter covers all four types.
  //   left : ({d, fill_l} << n) upper half
  //   right: ({fill_r, d} >> n) lower half
  // n = 0 leaves d untouched for every type.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    fill_l      = '0;
    fill_r      = '0;
    shift_carry = 1'b0;
    left_idx    = SW'(WORD_WIDTH - int'(s1_n));
    right_idx   = s1_n - SW'(1);

    case (s1_type)
      TYPE_LOGIC: begin
        fill_l = '0;
        fill_r = '0;
      end
      TYPE_ARITH: begin
        fill_l = '0;
        fill_r = {WORD_WIDTH{s1_d[WORD_WIDTH-1]}};
      end
      TYPE_DOUBLE: begin
        // Left takes the top n bits of c, right takes the bottom n bits of c.
        fill_l = {s1_c, 1'b0};
        fill_r = {1'b0, s1_c};
      end
      TYPE_CYCLIC: begin
        fill_l = s1_d;
        fill_r = s1_d;
      end
      default: begin
        fill_l = '0;
        fill_r = '0;
      end
    endcase

    if (s1_dir) begin
      shift_res = WORD_WIDTH'({fill_r, s1_d} >> s1_n);
    end else begin
      shift_res = WORD_WIDTH'(({s1_d, fill_l} << s1_n) >> WORD_WIDTH);
    end

    // Carry is the last bit of d to leave the word; indices are in range
    // whenever n is non-zero.
    if (s1_n != '0) begin
      shift_carry = s1_dir ? s1_d[right_idx] : s1_d[left_idx];
    end
  end

  // S1: operand capture
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1      <= 1'b0;
      s1_d    <= '0;
      s1_c    <= '0;
      s1_n    <= '0;
      s1_type <= '0;
      s1_dir  <= 1'b0;
      s1_tag  <= '0;
    end else begin
      // NOTE: flush only clears the valid bits; stale payload behind a
      // cleared valid is never observed, so data registers are left alone.
      if (flush_i) begin
        v1 <= 1'b0;
      end else if (s1_en) begin
        v1 <= in_valid_i;
      end
      if (s1_en && in_valid_i) begin
        s1_d    <= d_i;
        s1_c    <= c_i;
        s1_n    <= shift_size_i;
        s1_type <= shift_type_i;
        s1_dir  <= shift_dir_i;
        s1_tag  <= tag_i;
      end
    end
  end

  // S2: result register, drives the output ports directly
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      d_o         <= '0;
      carry_o     <= 1'b0;
      zero_o      <= 1'b0;
      tag_o       <= '0;
    end else begin
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (s2_en) begin
        out_valid_o <= v1;
      end
      if (s2_en && v1) begin
        d_o     <= shift_res;
        carry_o <= shift_carry;
        zero_o  <= (shift_res == '0);
        tag_o   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe_stage.sv
// tb_shift_pipe_stage
//   Self-checking bench for shift_pipe_stage (WORD_WIDTH=8, TAG_WIDTH=4).
//   Accepted operations push their expected result onto a scoreboard queue;
//   a monitor pops and compares on every output transfer. Directed vectors
//   come from a table; backpressure, streaming, flush and reset are
//   hand-written sequences. Expected values for random traffic come from a
//   bit-by-bit reference model.
module tb_shift_pipe_stage;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int SW = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  d_i;
  logic [W-2:0]  c_i;
  logic [SW-1:0] shift_size_i;
  logic [1:0]    shift_type_i;
  logic          shift_dir_i;
  logic [TW-1:0] tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  d_o;
  logic          carry_o;
  logic          zero_o;
  logic [TW-1:0] tag_o;

  shift_pipe_stage #(.WORD_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .d_i          (d_i),
    .c_i          (c_i),
    .shift_size_i (shift_size_i),
    .shift_type_i (shift_type_i),
    .shift_dir_i  (shift_dir_i),
    .tag_i        (tag_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .d_o          (d_o),
    .carry_o      (carry_o),
    .zero_o       (zero_o),
    .tag_o        (tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]  d;
    logic [W-2:0]  c;
    logic [SW-1:0] n;
    logic [1:0]    typ;
    logic          dir;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp_d;
    logic          exp_carry;
    logic          exp_zero;
  } vec_t;

  typedef struct {
    logic [W-1:0]  d;
    logic          carry;
    logic          zero;
    logic [TW-1:0] tag;
  } res_t;

  res_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: builds the result one output bit at a time.
  function automatic res_t model(input vec_t v);
    res_t r;
    int   n;
    n       = int'(v.n);
    r.d     = '0;
    r.tag   = v.tag;
    for (int i = 0; i < W; i++) begin
      if (!v.dir) begin
        if (i >= n) r.d[i] = v.d[i-n];
        else begin
          case (v.typ)
            2'd2:    r.d[i] = v.c[W-1-n+i];
            2'd3:    r.d[i] = v.d[i-n+W];
            default: r.d[i] = 1'b0;
          endcase
        end
      end else begin
        if (i + n <= W - 1) r.d[i] = v.d[i+n];
        else begin
          case (v.typ)
            2'd1:    r.d[i] = v.d[W-1];
            2'd2:    r.d[i] = v.c[i-(W-n)];
            2'd3:    r.d[i] = v.d[i+n-W];
            default: r.d[i] = 1'b0;
          endcase
        end
      end
    end
    if (n == 0)     r.carry = 1'b0;
    else if (v.dir) r.carry = v.d[n-1];
    else            r.carry = v.d[W-n];
    r.zero = (r.d == '0);
    return r;
  endfunction

  function automatic res_t table_exp(input vec_t v);
    res_t r;
    r.d     = v.exp_d;
    r.carry = v.exp_carry;
    r.zero  = v.exp_zero;
    r.tag   = v.tag;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_valid_i   = 1'b1;
    d_i          = v.d;
    c_i          = v.c;
    shift_size_i = v.n;
    shift_type_i = v.typ;
    shift_dir_i  = v.dir;
    tag_i        = v.tag;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input res_t e);
    drive(v);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        return;
      end
      @(posedge clk_i); #1;
    end
    fail_now("send_accept");
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50; k++) begin
      if (sb_q.size() == 0 && !out_valid_o) return;
      @(posedge clk_i); #1;
    end
    fail_now("drain");
  endtask

  // Scoreboard monitor: outputs are stable at the falling edge.
  always @(negedge clk_i) begin : monitor
    res_t e;
    if (rst_n_i && out_valid_o && out_ready_i) begin
      pops++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0h with empty scoreboard at %0t", tag_o, $time);
      end else begin
        e = sb_q.pop_front();
        check("res_d",     32'(d_o),     32'(e.d));
        check("res_carry", 32'(carry_o), 32'(e.carry));
        check("res_zero",  32'(zero_o),  32'(e.zero));
        check("res_tag",   32'(tag_o),   32'(e.tag));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[11];
  vec_t ops[4];
  vec_t v;
  logic [W-1:0]  held_d;
  int            acc;
  int            p0;

  initial begin
    tbl[0]  = '{d:8'hB3, c:7'h00, n:3'd3, typ:2'd0, dir:1'b0, tag:4'h1, exp_d:8'h98, exp_carry:1'b1, exp_zero:1'b0};
    tbl[1]  = '{d:8'h90, c:7'h00, n:3'd2, typ:2'd1, dir:1'b1, tag:4'h2, exp_d:8'hE4, exp_carry:1'b0, exp_zero:1'b0};
    tbl[2]  = '{d:8'h90, c:7'h00, n:3'd2, typ:2'd0, dir:1'b1, tag:4'h3, exp_d:8'h24, exp_carry:1'b0, exp_zero:1'b0};
    tbl[3]  = '{d:8'h0F, c:7'h50, n:3'd4, typ:2'd2, dir:1'b0, tag:4'h4, exp_d:8'hFA, exp_carry:1'b0, exp_zero:1'b0};
    tbl[4]  = '{d:8'h81, c:7'h00, n:3'd1, typ:2'd3, dir:1'b1, tag:4'h5, exp_d:8'hC0, exp_carry:1'b1, exp_zero:1'b0};
    tbl[5]  = '{d:8'h80, c:7'h00, n:3'd1, typ:2'd0, dir:1'b0, tag:4'h6, exp_d:8'h00, exp_carry:1'b1, exp_zero:1'b1};
    tbl[6]  = '{d:8'hA5, c:7'h7F, n:3'd0, typ:2'd1, dir:1'b1, tag:4'h7, exp_d:8'hA5, exp_carry:1'b0, exp_zero:1'b0};
    tbl[7]  = '{d:8'hF0, c:7'h03, n:3'd2, typ:2'd2, dir:1'b1, tag:4'h8, exp_d:8'hFC, exp_carry:1'b0, exp_zero:1'b0};
    tbl[8]  = '{d:8'h81, c:7'h00, n:3'd3, typ:2'd3, dir:1'b0, tag:4'h9, exp_d:8'h0C, exp_carry:1'b0, exp_zero:1'b0};
    tbl[9]  = '{d:8'h01, c:7'h00, n:3'd7, typ:2'd1, dir:1'b0, tag:4'hA, exp_d:8'h80, exp_carry:1'b0, exp_zero:1'b0};
    tbl[10] = '{d:8'h7F, c:7'h00, n:3'd7, typ:2'd1, dir:1'b1, tag:4'hB, exp_d:8'h00, exp_carry:1'b1, exp_zero:1'b1};

    rst_n_i      = 1'b0;
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b1;
    d_i          = '0;
    c_i          = '0;
    shift_size_i = '0;
    shift_type_i = '0;
    shift_dir_i  = 1'b0;
    tag_i        = '0;

    // Reset state
    #12;
    check("rst_in_ready",  32'(in_ready_o),  32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_d",         32'(d_o),         32'd0);
    check("rst_carry",     32'(carry_o),     32'd0);
    check("rst_zero",      32'(zero_o),      32'd0);
    check("rst_tag",       32'(tag_o),       32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Latency: registered into S1 on the accepting edge, visible from S2
    // after the following edge.
    send(tbl[0], table_exp(tbl[0]));
    in_valid_i = 1'b0;
    check("lat_s1_only", 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check("lat_s2_valid", 32'(out_valid_o), 32'd1);
    wait_drain();

    // Directed table, back-to-back
    for (int i = 0; i < 11; i++) send(tbl[i], table_exp(tbl[i]));
    in_valid_i = 1'b0;
    wait_drain();

    // Backpressure: consumer stalled, four ops offered back-to-back
    for (int i = 0; i < 4; i++) begin
      ops[i].d   = W'($urandom);
      ops[i].c   = (W-1)'($urandom);
      ops[i].n   = SW'(i + 1);
      ops[i].typ = 2'(i);
      ops[i].dir = i[0];
      ops[i].tag = TW'(i + 1);
    end
    out_ready_i = 1'b0;
    acc         = 0;
    held_d      = '0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(ops[acc]);
      @(negedge clk_i);
      if (cyc >= 2) begin
        check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
        check("bp_hold_tag", 32'(tag_o), 32'd1);
      end
      if (cyc == 2) held_d = d_o;
      if (cyc == 3) check("bp_hold_d", 32'(d_o), 32'(held_d));
      if (in_ready_o) begin
        sb_q.push_back(model(ops[acc]));
        acc++;
      end
      @(posedge clk_i); #1;
    end
    check("bp_accepts", 32'(acc), 32'd2);
    out_ready_i = 1'b1;
    p0 = pops;
    send(ops[2], model(ops[2]));
    send(ops[3], model(ops[3]));
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("bp_release_rate", 32'(pops - p0), 32'd4);
    wait_drain();

    // Streaming: 16 random ops, one result per cycle
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      v.d   = W'($urandom);
      v.c   = (W-1)'($urandom);
      v.n   = (i % 5 == 0) ? '0 : SW'($urandom_range(0, W-1));
      v.typ = 2'($urandom_range(0, 3));
      v.dir = 1'($urandom_range(0, 1));
      v.tag = TW'(i);
      send(v, model(v));
    end
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("stream_throughput", 32'(pops - p0), 32'd16);
    wait_drain();

    // Flush with two ops in flight plus an offer in the flush cycle
    out_ready_i = 1'b0;
    drive(tbl[1]);
    @(posedge clk_i); #1;
    drive(tbl[2]);
    @(posedge clk_i); #1;
    check("flush_pre_valid", 32'(out_valid_o), 32'd1);
    flush_i = 1'b1;
    drive(tbl[3]);
    @(posedge clk_i); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_out_valid", 32'(out_valid_o), 32'd0);
    check("flush_in_ready",  32'(in_ready_o),  32'd1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("flush_no_ghost", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;

    // Asynchronous reset mid-operation
    out_ready_i = 1'b0;
    send(tbl[4], table_exp(tbl[4]));
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("arst_pre_valid", 32'(out_valid_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_o), 32'd0);
    check("arst_d",         32'(d_o),         32'd0);
    sb_q.delete();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    check("arst_in_ready",  32'(in_ready_o),  32'd1);
    check("arst_idle",      32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;
    send(tbl[5], table_exp(tbl[5]));
    in_valid_i = 1'b0;
    wait_drain();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
